// File: rtl/alu_pkg.sv
// Shared ALU definitions: 3-bit ALU op codes, major opcodes, default datapath width.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  // Source of the second ALU operand.
  typedef enum logic [1:0] {
    OPND_REG       = 2'd0,  // rs2 read data (or bypass)
    OPND_IMM_SEXT  = 2'd1,  // imm sign-extended to DATA_W
    OPND_IMM_SHAMT = 2'd2   // imm[4:0] zero-extended (shift amount)
  } opnd2_sel_e;

  // funct3 -> ALU op, shared by R and I forms. 'alt' picks sub over add
  // and sra over srl; the caller decides where that bit comes from.
  function automatic logic [2:0] funct3_to_alu(input logic [2:0] f3, input logic alt);
    logic [2:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b100:  op = ALU_XOR;
      3'b001:  op = ALU_SLL;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Instruction field decode into ALU op, illegal flag and operand-2 select.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports: opcode/funct3/funct7/imm in; alu_ctrl, illegal, opnd2_sel, is_rtype out.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm,
  output logic [2:0]  alu_ctrl,
  output logic        illegal,
  output opnd2_sel_e  opnd2_sel,
  output logic        is_rtype
);

  logic is_shift;
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    alu_ctrl  = ALU_ADD;
    illegal   = 1'b0;
    opnd2_sel = OPND_REG;
    is_rtype  = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        is_rtype = 1'b1;
        alu_ctrl = funct3_to_alu(funct3, funct7[5]);
      end
      OPC_ITYPE: begin
        // Immediate add has no subtract form; only the shift-right uses imm[10].
        alu_ctrl  = funct3_to_alu(funct3, (funct3 == 3'b101) && imm[10]);
        opnd2_sel = is_shift ? OPND_IMM_SHAMT : OPND_IMM_SEXT;
      end
      default: illegal = 1'b1;
    endcase
    // slt/sltu encodings are not supported by this ALU.
    if ((funct3 == 3'b010) || (funct3 == 3'b011)) illegal = 1'b1;
    if (illegal) begin
      alu_ctrl  = ALU_ADD;
      opnd2_sel = OPND_REG;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{funct7[6], funct7[4:0], imm[11], imm[9:0]};

endmodule

// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register: decodes ALU op, selects operands, holds them for EX.
// Latency: one cycle from accept (valid_i && ready_o) to valid_o.
// Backpressure: ready_o = !valid_o || ready_i; outputs hold while stalled, stall_cnt_o saturates.
//
// Ports: clk_i, rst_n_i (async, active-low); upstream valid_i/ready_o with
// instruction fields and register data; fwd_* EX bypass; flush_i; downstream
// valid_o/ready_i with data1_o, data2_o, ALUCtrl_o, rd_o, regwrite_o, illegal_o;
// stall_cnt_o back-pressure counter.
// Optional feature macro: ID_EX_ALU_FWD_EN enables the EX-result bypass.
module id_ex_alu_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [11:0]       imm_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [4:0]        rd_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic              fwd_valid_i,
  input  logic [4:0]        fwd_rd_i,
  input  logic [DATA_W-1:0] fwd_data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [2:0]        ALUCtrl_o,
  output logic [4:0]        rd_o,
  output logic              regwrite_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [2:0]  dec_alu_ctrl;
  logic        dec_illegal;
  opnd2_sel_e  dec_opnd2_sel;
  logic        dec_is_rtype;

  alu_ctrl_decode u_decode (
    .opcode    (opcode_i),
    .funct3    (funct3_i),
    .funct7    (funct7_i),
    .imm       (imm_i),
    .alu_ctrl  (dec_alu_ctrl),
    .illegal   (dec_illegal),
    .opnd2_sel (dec_opnd2_sel),
    .is_rtype  (dec_is_rtype)
  );

  // Register operands, optionally bypassed from the EX result.
  logic [DATA_W-1:0] rs1_opnd;
  logic [DATA_W-1:0] rs2_opnd;

`ifdef ID_EX_ALU_FWD_EN
  logic fwd_hit1;
  logic fwd_hit2;
  assign fwd_hit1 = fwd_valid_i && (fwd_rd_i != 5'd0) && (fwd_rd_i == rs1_i);
  // rs2 is only a real source on R-type; the I-type rs2 field is immediate bits.
  assign fwd_hit2 = fwd_valid_i && (fwd_rd_i != 5'd0) && (fwd_rd_i == rs2_i) && dec_is_rtype;
  assign rs1_opnd = fwd_hit1 ? fwd_data_i : rs1_data_i;
  assign rs2_opnd = fwd_hit2 ? fwd_data_i : rs2_data_i;
`else
  assign rs1_opnd = rs1_data_i;
  assign rs2_opnd = rs2_data_i;
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid_i, fwd_rd_i, fwd_data_i, rs1_i, rs2_i, dec_is_rtype};
`endif

  logic [DATA_W-1:0] opnd2;
  always_comb begin
    opnd2 = rs2_opnd;
    case (dec_opnd2_sel)
      OPND_IMM_SEXT:  opnd2 = {{(DATA_W-12){imm_i[11]}}, imm_i};
      OPND_IMM_SHAMT: opnd2 = {{(DATA_W-5){1'b0}}, imm_i[4:0]};
      default:        opnd2 = rs2_opnd;
    endcase
  end

  logic accept;
  logic stalled;
  assign ready_o = !valid_o || ready_i;
  assign accept  = valid_i && ready_o;
  assign stalled = valid_o && !ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o     <= 1'b0;
      data1_o     <= '0;
      data2_o     <= '0;
      ALUCtrl_o   <= ALU_ADD;
      rd_o        <= 5'd0;
      regwrite_o  <= 1'b0;
      illegal_o   <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      // Flush wins over an accept in the same cycle.
      if (flush_i) begin
        valid_o <= 1'b0;
      end else if (accept) begin
        valid_o    <= 1'b1;
        data1_o    <= rs1_opnd;
        data2_o    <= opnd2;
        ALUCtrl_o  <= dec_alu_ctrl;
        rd_o       <= rd_i;
        regwrite_o <= !dec_illegal && (rd_i != 5'd0);
        illegal_o  <= dec_illegal;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end

      if (stalled && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Directed bench for id_ex_alu_stage with a scoreboard of expected outputs.
// Latency: expects results one edge after each accept.
// Backpressure: exercises stalls, saturation (second instance with CNT_W=4), flush and reset.
module tb_id_ex_alu_stage;

`ifdef ID_EX_ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i, flush_i, ready_i, fwd_valid_i;
  logic [6:0]  opcode_i, funct7_i;
  logic [2:0]  funct3_i;
  logic [11:0] imm_i;
  logic [4:0]  rs1_i, rs2_i, rd_i, fwd_rd_i;
  logic [31:0] rs1_data_i, rs2_data_i, fwd_data_i;

  logic        ready_o, valid_o, regwrite_o, illegal_o;
  logic [31:0] data1_o, data2_o;
  logic [2:0]  alu_ctrl_o;
  logic [4:0]  rd_o;
  logic [15:0] stall_cnt_o;

  logic        d4_ready, d4_valid, d4_regwrite, d4_illegal;
  logic [31:0] d4_data1, d4_data2;
  logic [2:0]  d4_alu_ctrl;
  logic [4:0]  d4_rd;
  logic [3:0]  d4_stall_cnt;

  always #5 clk_i = ~clk_i;

  id_ex_alu_stage #(.DATA_W(32), .CNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .fwd_valid_i(fwd_valid_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(alu_ctrl_o),
    .rd_o(rd_o), .regwrite_o(regwrite_o), .illegal_o(illegal_o),
    .stall_cnt_o(stall_cnt_o)
  );

  id_ex_alu_stage #(.DATA_W(32), .CNT_W(4)) u_dut4 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(d4_ready),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .fwd_valid_i(fwd_valid_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
    .flush_i(flush_i), .valid_o(d4_valid), .ready_i(ready_i),
    .data1_o(d4_data1), .data2_o(d4_data2), .ALUCtrl_o(d4_alu_ctrl),
    .rd_o(d4_rd), .regwrite_o(d4_regwrite), .illegal_o(d4_illegal),
    .stall_cnt_o(d4_stall_cnt)
  );

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
    bit          chk_data;  // operand values are don't-care for illegal entries
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t mk(input logic [2:0] ctrl, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [4:0] rd, input logic rw, input logic ill, input bit cd);
    exp_t e;
    e.ctrl = ctrl; e.d1 = d1; e.d2 = d2; e.rd = rd; e.rw = rw; e.ill = ill; e.chk_data = cd;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_entry(input string tag, input exp_t e);
    chk($sformatf("%s.ctrl", tag), {61'd0, alu_ctrl_o}, {61'd0, e.ctrl});
    chk($sformatf("%s.rd", tag), {59'd0, rd_o}, {59'd0, e.rd});
    chk($sformatf("%s.regwrite", tag), {63'd0, regwrite_o}, {63'd0, e.rw});
    chk($sformatf("%s.illegal", tag), {63'd0, illegal_o}, {63'd0, e.ill});
    if (e.chk_data) begin
      chk($sformatf("%s.data1", tag), {32'd0, data1_o}, {32'd0, e.d1});
      chk($sformatf("%s.data2", tag), {32'd0, data2_o}, {32'd0, e.d2});
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] r1d, input logic [31:0] r2d);
    valid_i = 1'b1; opcode_i = op; funct3_i = f3; funct7_i = f7; imm_i = imm;
    rs1_i = rs1; rs2_i = rs2; rd_i = rd; rs1_data_i = r1d; rs2_data_i = r2d;
  endtask

  // One edge after an accept: the entry must be presented and match the scoreboard head.
  task automatic expect_out(input string tag);
    exp_t e;
    @(posedge clk_i); #1;
    chk($sformatf("%s.valid", tag), {63'd0, valid_o}, 64'd1);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      held = e;
      chk_entry(tag, e);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [11:0] imm, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] r1d,
                      input logic [31:0] r2d, input exp_t e);
    @(negedge clk_i);
    drive(op, f3, f7, imm, rs1, rs2, rd, r1d, r2d);
    sb.push_back(e);
    expect_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    fwd_valid_i = 1'b0; fwd_rd_i = 5'd0; fwd_data_i = 32'd0;
    opcode_i = 7'd0; funct3_i = 3'd0; funct7_i = 7'd0; imm_i = 12'd0;
    rs1_i = 5'd0; rs2_i = 5'd0; rd_i = 5'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
    #2;
    chk("rst.valid", {63'd0, valid_o}, 64'd0);
    chk("rst.ready", {63'd0, ready_o}, 64'd1);
    chk_entry("rst", mk(3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1));
    chk("rst.stall_cnt", {48'd0, stall_cnt_o}, 64'd0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    // R-type decode
    step("r_sub", 7'b0110011, 3'b000, 7'b0100000, 12'd0, 5'd1, 5'd2, 5'd3, 32'h20, 32'h20,
         mk(3'b001, 32'h20, 32'h20, 5'd3, 1'b1, 1'b0, 1'b1));
    step("r_add", 7'b0110011, 3'b000, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd9, 32'h7, 32'h3,
         mk(3'b000, 32'h7, 32'h3, 5'd9, 1'b1, 1'b0, 1'b1));
    step("r_and", 7'b0110011, 3'b111, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd4, 32'hF0F0, 32'h0FF0,
         mk(3'b010, 32'hF0F0, 32'h0FF0, 5'd4, 1'b1, 1'b0, 1'b1));
    step("r_or", 7'b0110011, 3'b110, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2,
         mk(3'b011, 32'h1, 32'h2, 5'd5, 1'b1, 1'b0, 1'b1));
    step("r_xor", 7'b0110011, 3'b100, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd6, 32'hA, 32'h5,
         mk(3'b100, 32'hA, 32'h5, 5'd6, 1'b1, 1'b0, 1'b1));
    step("r_sll", 7'b0110011, 3'b001, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd7, 32'h1, 32'h4,
         mk(3'b101, 32'h1, 32'h4, 5'd7, 1'b1, 1'b0, 1'b1));
    step("r_sra", 7'b0110011, 3'b101, 7'b0100000, 12'd0, 5'd1, 5'd2, 5'd8, 32'h80000000, 32'h4,
         mk(3'b110, 32'h80000000, 32'h4, 5'd8, 1'b1, 1'b0, 1'b1));
    step("r_srl", 7'b0110011, 3'b101, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd8, 32'h80000000, 32'h4,
         mk(3'b111, 32'h80000000, 32'h4, 5'd8, 1'b1, 1'b0, 1'b1));
    step("r_rd0", 7'b0110011, 3'b000, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd0, 32'h1, 32'h1,
         mk(3'b000, 32'h1, 32'h1, 5'd0, 1'b0, 1'b0, 1'b1));

    // I-type decode: sign-extended immediate, shamt forms, no subtract
    step("i_add_neg", 7'b0010011, 3'b000, 7'b0000000, 12'hFF0, 5'd1, 5'd2, 5'd3, 32'h10, 32'hDEAD,
         mk(3'b000, 32'h10, 32'hFFFFFFF0, 5'd3, 1'b1, 1'b0, 1'b1));
    step("i_add_f7", 7'b0010011, 3'b000, 7'b0100000, 12'h7FF, 5'd1, 5'd2, 5'd3, 32'h10, 32'hDEAD,
         mk(3'b000, 32'h10, 32'h000007FF, 5'd3, 1'b1, 1'b0, 1'b1));
    step("i_srai", 7'b0010011, 3'b101, 7'b0000000, 12'h402, 5'd1, 5'd2, 5'd3, 32'h40, 32'hDEAD,
         mk(3'b110, 32'h40, 32'h2, 5'd3, 1'b1, 1'b0, 1'b1));
    step("i_srli", 7'b0010011, 3'b101, 7'b0000000, 12'h01F, 5'd1, 5'd2, 5'd3, 32'h40, 32'hDEAD,
         mk(3'b111, 32'h40, 32'h1F, 5'd3, 1'b1, 1'b0, 1'b1));
    step("i_slli", 7'b0010011, 3'b001, 7'b0000000, 12'hFE3, 5'd1, 5'd2, 5'd3, 32'h40, 32'hDEAD,
         mk(3'b101, 32'h40, 32'h3, 5'd3, 1'b1, 1'b0, 1'b1));

    // Unsupported encodings pass through flagged
    step("ill_load", 7'b0000011, 3'b000, 7'b0000000, 12'h004, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2,
         mk(3'b000, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0));
    step("ill_slt", 7'b0110011, 3'b010, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2,
         mk(3'b000, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0));

    // Bubble: nothing offered, ready downstream -> valid drops
    @(negedge clk_i); valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("bubble.valid", {63'd0, valid_o}, 64'd0);
    chk("bubble.stall_cnt", {48'd0, stall_cnt_o}, 64'd0);

    // Short stall: outputs hold, counter reaches 5, pending entry waits
    step("stall_a", 7'b0110011, 3'b100, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd11, 32'h1234, 32'h5678,
         mk(3'b100, 32'h1234, 32'h5678, 5'd11, 1'b1, 1'b0, 1'b1));
    @(negedge clk_i);
    ready_i = 1'b0;
    drive(7'b0110011, 3'b111, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd12, 32'hAAAA, 32'h00FF);
    #1;
    chk("stall.ready_o", {63'd0, ready_o}, 64'd0);
    repeat (5) @(posedge clk_i);
    #1;
    chk("stall.valid", {63'd0, valid_o}, 64'd1);
    chk_entry("stall_hold", held);
    chk("stall.cnt5", {48'd0, stall_cnt_o}, 64'd5);
    chk("stall.cnt5_w4", {60'd0, d4_stall_cnt}, 64'd5);
    @(negedge clk_i);
    ready_i = 1'b1;
    sb.push_back(mk(3'b010, 32'hAAAA, 32'h00FF, 5'd12, 1'b1, 1'b0, 1'b1));
    expect_out("stall_b");
    chk("stall.cnt_after", {48'd0, stall_cnt_o}, 64'd5);

    // Long stall: 16-bit counter keeps counting, 4-bit one saturates
    @(negedge clk_i); ready_i = 1'b0; valid_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    chk("sat.cnt16", {48'd0, stall_cnt_o}, 64'd25);
    chk("sat.cnt4", {60'd0, d4_stall_cnt}, 64'hF);
    @(negedge clk_i); ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("drain.valid", {63'd0, valid_o}, 64'd0);
    chk("drain.cnt4", {60'd0, d4_stall_cnt}, 64'hF);

    // Flush beats an accept in the same cycle
    step("pre_flush", 7'b0010011, 3'b110, 7'b0000000, 12'h00F, 5'd1, 5'd2, 5'd13, 32'hF0, 32'h0,
         mk(3'b011, 32'hF0, 32'hF, 5'd13, 1'b1, 1'b0, 1'b1));
    @(negedge clk_i);
    flush_i = 1'b1;
    drive(7'b0110011, 3'b000, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd14, 32'h9, 32'h9);
    @(posedge clk_i); #1;
    chk("flush.valid", {63'd0, valid_o}, 64'd0);
    @(negedge clk_i); flush_i = 1'b0; valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("flush.no_capture", {63'd0, valid_o}, 64'd0);

    // Asynchronous reset in the middle of a stall
    step("pre_rst", 7'b0110011, 3'b001, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd15, 32'h3, 32'h1,
         mk(3'b101, 32'h3, 32'h1, 5'd15, 1'b1, 1'b0, 1'b1));
    @(negedge clk_i); ready_i = 1'b0; valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("arst.valid", {63'd0, valid_o}, 64'd0);
    chk_entry("arst", mk(3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1));
    chk("arst.stall_cnt", {48'd0, stall_cnt_o}, 64'd0);
    chk("arst.stall_cnt_w4", {60'd0, d4_stall_cnt}, 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1; ready_i = 1'b1;
    drive(7'b0110011, 3'b110, 7'b0000000, 12'd0, 5'd1, 5'd2, 5'd16, 32'h5, 32'hA);
    sb.push_back(mk(3'b011, 32'h5, 32'hA, 5'd16, 1'b1, 1'b0, 1'b1));
    expect_out("post_rst");

    // Bypass: hit on rs1, x0 never bypasses, immediates never bypass
    fwd_valid_i = 1'b1; fwd_rd_i = 5'd5; fwd_data_i = 32'h1234;
    step("fwd_rs1", 7'b0110011, 3'b000, 7'b0000000, 12'd0, 5'd5, 5'd6, 5'd7, 32'h1111, 32'h2222,
         mk(3'b000, FWD ? 32'h1234 : 32'h1111, 32'h2222, 5'd7, 1'b1, 1'b0, 1'b1));
    step("fwd_rs2", 7'b0110011, 3'b000, 7'b0000000, 12'd0, 5'd6, 5'd5, 5'd7, 32'h1111, 32'h2222,
         mk(3'b000, 32'h1111, FWD ? 32'h1234 : 32'h2222, 5'd7, 1'b1, 1'b0, 1'b1));
    step("fwd_imm", 7'b0010011, 3'b000, 7'b0000000, 12'h005, 5'd6, 5'd5, 5'd7, 32'h1111, 32'h2222,
         mk(3'b000, 32'h1111, 32'h5, 5'd7, 1'b1, 1'b0, 1'b1));
    fwd_rd_i = 5'd0;
    step("fwd_x0", 7'b0110011, 3'b000, 7'b0000000, 12'd0, 5'd0, 5'd6, 5'd7, 32'h3333, 32'h2222,
         mk(3'b000, 32'h3333, 32'h2222, 5'd7, 1'b1, 1'b0, 1'b1));
    fwd_valid_i = 1'b0;

    @(negedge clk_i); valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("end.valid", {63'd0, valid_o}, 64'd0);
    chk("end.sb_empty", {32'd0, 32'(sb.size())}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
